hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- RA_W, 5, register-address width.
- MEM_LAT, 1, data-memory latency in cycles (1..8).
- CNT_W, 16, performance-counter width.

REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.

REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- branch_d  in  1  branch in decode
- jump_reg_d  in  1  jr in decode
- pc_src_d  in  1  taken branch/jump redirect
- rs_d, rt_d  in  RA_W  decode sources
- rs_e, rt_e  in  RA_W  execute sources
- write_reg_e  in  RA_W  execute destination
- reg_write_e, mem_to_reg_e  in  1  execute controls
- write_reg_m  in  RA_W  memory destination
- reg_write_m, mem_to_reg_m  in  1  memory controls
- mem_req_m  in  1  load/store active in M
- write_reg_w  in  RA_W  writeback destination
- reg_write_w  in  1  writeback enable
- cnt_clr  in  1  synchronous counter clear
- stall_f, stall_d, stall_e, stall_m  out  1  stage holds
- flush_d, flush_e, flush_w  out  1  bubble inserts
- forward_ad, forward_bd  out  1  decode compare forwards from M
- forward_ae, forward_be  out  2  execute operand select
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Function
REQ-004 Register 0 SHALL never match for any forward or stall comparison.
REQ-005 forward_ae SHALL be 2'b10 if reg_write_m and write_reg_m==rs_e; else 2'b01 if reg_write_w and write_reg_w==rs_e; else 2'b00. M SHALL take priority over W. forward_be SHALL follow the same rule on rt_e.
REQ-006 forward_ad SHALL equal reg_write_m && write_reg_m==rs_d; forward_bd SHALL be the same on rt_d.
REQ-007 lw_stall SHALL equal mem_to_reg_e && reg_write_e && write_reg_e matching rs_d or rt_d.
REQ-008 br_stall SHALL equal (branch_d||jump_reg_d) && ((reg_write_e && write_reg_e matching rs_d/rt_d) || (mem_to_reg_m && write_reg_m matching rs_d/rt_d)).
REQ-009 mem_stall SHALL be the memory-wait FSM output.
  - States: IDLE, WAIT; a down-counter rem of width clog2(MEM_LAT).
  - IDLE with mem_req_m && MEM_LAT>1: mem_stall=1; go to WAIT; rem<=MEM_LAT-2.
  - WAIT with rem!=0: mem_stall=1; rem decrements.
  - WAIT with rem==0: mem_stall=0; return to IDLE. mem_req_m SHALL NOT retrigger in this cycle.
  - The result is exactly MEM_LAT-1 stall cycles per access.
  - MEM_LAT==1: the FSM SHALL stay in IDLE and mem_stall SHALL stay 0.
REQ-010 When mem_stall=1:
  - stall_f=stall_d=stall_e=stall_m=1 and flush_w=1.
  - flush_e=0 and flush_d=0.
  - lw_stall and br_stall SHALL be masked.
REQ-011 When mem_stall=0 and (lw_stall||br_stall): stall_f=stall_d=flush_e=1; stall_e=stall_m=flush_w=0.
REQ-012 flush_d SHALL equal pc_src_d && !stall_d.
REQ-013 All stall, flush and forward outputs SHALL be combinational from inputs and FSM state, with zero-cycle latency.
REQ-014 stall_cnt SHALL increment each cycle stall_f=1. flush_cnt SHALL increment each cycle (flush_d||flush_e)=1.
  - Both SHALL saturate at all-ones.
  - cnt_clr SHALL zero both on the next edge, taking priority over increment.

Reset
REQ-015 rst_n low SHALL asynchronously set the FSM to IDLE, rem=0, stall_cnt=0 and flush_cnt=0; mem_stall SHALL be 0 while in reset.
REQ-016 Reset asserted mid-WAIT SHALL abandon the access. After release the next mem_req_m SHALL start a fresh MEM_LAT sequence.

Structure
REQ-017 Package pipe_pkg SHALL hold the FWD_NONE=2'b00, FWD_WB=2'b01 and FWD_MEM=2'b10 constants and the memwait state enum.
REQ-018 One sub-module, sat_counter (params W; ports clk, rst_n, clr, inc, q), SHALL be instantiated twice for the two counters.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  - EX/WB forward: reg_write_m=1, write_reg_m=8, rs_e=8, reg_write_w=1, write_reg_w=8 -> forward_ae=2'b10. Same with rs_e=0 -> 2'b00.
  - Load-use: mem_to_reg_e=1, reg_write_e=1, write_reg_e=9, rt_d=9 -> stall_f=stall_d=flush_e=1 for one cycle; stall_cnt +1.
  - Branch hazard: branch_d=1, rs_d=4, write_reg_m=4, mem_to_reg_m=1 -> stall asserted. Same with mem_to_reg_m=0, reg_write_m=1 -> no stall, forward_ad=1.
  - MEM_LAT=4: mem_req_m held 4 cycles -> stall_m=1 for exactly 3 cycles then 0. flush_e=0 throughout; stall_cnt=3.
  - Reset during WAIT (MEM_LAT=4, cycle 2) -> stall_m=0 immediately, counters 0. A new mem_req_m gives 3 stall cycles again.
  - Saturation (CNT_W=2): 5 stall cycles -> stall_cnt=3. cnt_clr together with stall -> 0 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline hazard unit: forward-select encodings
// and the memory-wait state machine states.
package pipe_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic {
    MW_IDLE = 1'b0,
    MW_WAIT = 1'b1
  } memwait_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones; a clear wins over an increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use/branch interlocks,
// multi-cycle data-memory wait, and saturating stall/flush counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RA_W    = 5,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             branch_d,
  input  logic             jump_reg_d,
  input  logic             pc_src_d,
  input  logic [RA_W-1:0]  rs_d,
  input  logic [RA_W-1:0]  rt_d,
  input  logic [RA_W-1:0]  rs_e,
  input  logic [RA_W-1:0]  rt_e,
  input  logic [RA_W-1:0]  write_reg_e,
  input  logic             reg_write_e,
  input  logic             mem_to_reg_e,
  input  logic [RA_W-1:0]  write_reg_m,
  input  logic             reg_write_m,
  input  logic             mem_to_reg_m,
  input  logic             mem_req_m,
  input  logic [RA_W-1:0]  write_reg_w,
  input  logic             reg_write_w,
  input  logic             cnt_clr,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             forward_ad,
  output logic             forward_bd,
  output logic [1:0]       forward_ae,
  output logic [1:0]       forward_be,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // A zero-width down-counter is illegal, so MEM_LAT==1 keeps a dummy bit.
  localparam int              REM_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam bit              LONG_LAT = (MEM_LAT > 1);
  localparam logic [REM_W-1:0] REM_INIT = REM_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  memwait_e         state;
  logic [REM_W-1:0] rem;
  logic             mem_stall;
  logic             lw_stall;
  logic             br_stall;
  logic             hz_stall;

  function automatic logic hit(input logic [RA_W-1:0] a, input logic [RA_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                         input logic            wr_m,
                                         input logic [RA_W-1:0] dst_m,
                                         input logic            wr_w,
                                         input logic [RA_W-1:0] dst_w);
    if (wr_m && hit(dst_m, src))      return FWD_MEM;
    else if (wr_w && hit(dst_w, src)) return FWD_WB;
    else                              return FWD_NONE;
  endfunction

  // Memory-wait FSM: MEM_LAT-1 stall cycles per access, no retrigger on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MW_IDLE;
      rem   <= '0;
    end else begin
      case (state)
        MW_IDLE: begin
          if (mem_req_m && LONG_LAT) begin
            state <= MW_WAIT;
            rem   <= REM_INIT;
          end
        end
        MW_WAIT: begin
          if (rem != '0) rem <= rem - REM_W'(1);
          else           state <= MW_IDLE;
        end
        default: state <= MW_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_stall = 1'b0;
    if (rst_n) begin
      if (state == MW_IDLE) mem_stall = mem_req_m && LONG_LAT;
      else                  mem_stall = (rem != '0);
    end
  end

  always_comb begin
    forward_ae = fwd_sel(rs_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);
    forward_be = fwd_sel(rt_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);
    forward_ad = reg_write_m && hit(write_reg_m, rs_d);
    forward_bd = reg_write_m && hit(write_reg_m, rt_d);

    lw_stall = mem_to_reg_e && reg_write_e &&
               (hit(write_reg_e, rs_d) || hit(write_reg_e, rt_d));
    br_stall = (branch_d || jump_reg_d) &&
               ((reg_write_e && (hit(write_reg_e, rs_d) || hit(write_reg_e, rt_d))) ||
                (mem_to_reg_m && (hit(write_reg_m, rs_d) || hit(write_reg_m, rt_d))));
    // Decode interlocks are moot while the whole pipe is frozen on memory.
    hz_stall = !mem_stall && (lw_stall || br_stall);

    stall_f = mem_stall || hz_stall;
    stall_d = mem_stall || hz_stall;
    stall_e = mem_stall;
    stall_m = mem_stall;
    flush_w = mem_stall;
    flush_e = hz_stall;
    flush_d = pc_src_d && !stall_d;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (stall_f),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (flush_d || flush_e),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a MEM_LAT=4 instance and a narrow-counter
// MEM_LAT=1 instance share one stimulus stream.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       branch_d, jump_reg_d, pc_src_d;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, mem_to_reg_e, reg_write_m, mem_to_reg_m, mem_req_m;
  logic       reg_write_w, cnt_clr;

  logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic        forward_ad, forward_bd;
  logic [1:0]  forward_ae, forward_be;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_stall_f, s_stall_d, s_stall_e, s_stall_m, s_flush_d, s_flush_e, s_flush_w;
  logic        s_forward_ad, s_forward_bd;
  logic [1:0]  s_forward_ae, s_forward_be;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int passed = 0;
  int nstall;

  always #5 clk = ~clk;

  hazard_ctrl #(.RA_W(5), .MEM_LAT(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .branch_d(branch_d), .jump_reg_d(jump_reg_d),
    .pc_src_d(pc_src_d), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
    .write_reg_m(write_reg_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
    .mem_req_m(mem_req_m), .write_reg_w(write_reg_w), .reg_write_w(reg_write_w),
    .cnt_clr(cnt_clr), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .stall_m(stall_m), .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .forward_ad(forward_ad), .forward_bd(forward_bd), .forward_ae(forward_ae),
    .forward_be(forward_be), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.RA_W(5), .MEM_LAT(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .branch_d(branch_d), .jump_reg_d(jump_reg_d),
    .pc_src_d(pc_src_d), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
    .write_reg_m(write_reg_m), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
    .mem_req_m(mem_req_m), .write_reg_w(write_reg_w), .reg_write_w(reg_write_w),
    .cnt_clr(cnt_clr), .stall_f(s_stall_f), .stall_d(s_stall_d), .stall_e(s_stall_e),
    .stall_m(s_stall_m), .flush_d(s_flush_d), .flush_e(s_flush_e), .flush_w(s_flush_w),
    .forward_ad(s_forward_ad), .forward_bd(s_forward_bd), .forward_ae(s_forward_ae),
    .forward_be(s_forward_be), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    branch_d = 0; jump_reg_d = 0; pc_src_d = 0;
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    write_reg_e = 0; reg_write_e = 0; mem_to_reg_e = 0;
    write_reg_m = 0; reg_write_m = 0; mem_to_reg_m = 0; mem_req_m = 0;
    write_reg_w = 0; reg_write_w = 0; cnt_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use();
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 9; rt_d = 9;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #12;
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_flush_cnt", 32'(flush_cnt), 0);
    chk("reset_stall_m", 32'(stall_m), 0);
    rst_n = 1;
    tick();

    // Forwarding: M beats W; register 0 never forwards.
    reg_write_m = 1; write_reg_m = 8; rs_e = 8; reg_write_w = 1; write_reg_w = 8;
    #1 chk("fwd_ae_mem", 32'(forward_ae), 2'b10);
    rs_e = 0;
    #1 chk("fwd_ae_r0", 32'(forward_ae), 2'b00);
    reg_write_m = 0; rt_e = 8;
    #1 chk("fwd_be_wb", 32'(forward_be), 2'b01);
    idle_inputs();
    tick();

    // Load-use interlock with a redirect in flight that must not flush decode.
    load_use(); pc_src_d = 1;
    #1;
    chk("lu_stall_f", 32'(stall_f), 1);
    chk("lu_stall_d", 32'(stall_d), 1);
    chk("lu_flush_e", 32'(flush_e), 1);
    chk("lu_stall_e", 32'(stall_e), 0);
    chk("lu_flush_w", 32'(flush_w), 0);
    chk("lu_flush_d", 32'(flush_d), 0);
    tick();
    idle_inputs();
    #1;
    chk("lu_after_stall_f", 32'(stall_f), 0);
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    chk("lu_flush_cnt", 32'(flush_cnt), 1);
    pc_src_d = 1;
    #1 chk("redirect_flush_d", 32'(flush_d), 1);
    tick();
    idle_inputs();
    #1 chk("redirect_flush_cnt", 32'(flush_cnt), 2);

    // Register 0 destination must not interlock.
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 0; rs_d = 0;
    #1 chk("lu_r0_no_stall", 32'(stall_f), 0);
    idle_inputs();

    // Branch compare against a load in M stalls; an ALU result in M forwards.
    branch_d = 1; rs_d = 4; write_reg_m = 4; mem_to_reg_m = 1;
    #1 chk("br_load_stall", 32'(stall_f), 1);
    mem_to_reg_m = 0; reg_write_m = 1;
    #1 chk("br_alu_no_stall", 32'(stall_f), 0);
    chk("br_forward_ad", 32'(forward_ad), 1);
    jump_reg_d = 1; branch_d = 0; reg_write_e = 1; write_reg_e = 4; reg_write_m = 0;
    #1 chk("jr_exec_stall", 32'(stall_f), 1);
    idle_inputs();
    tick();

    // Clear, then a 4-cycle memory access with a coincident load-use hazard.
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    #1 chk("clr_stall_cnt", 32'(stall_cnt), 0);
    for (int i = 0; i < 4; i++) begin
      mem_req_m = 1;
      if (i == 0) load_use();
      #1;
      chk($sformatf("mem_stall_m_%0d", i), 32'(stall_m), (i < 3) ? 1 : 0);
      chk($sformatf("mem_flush_e_%0d", i), 32'(flush_e), 0);
      if (i == 0) chk("mem_flush_w", 32'(flush_w), 1);
      if (i == 0) chk("lat1_stall_m", 32'(s_stall_m), 0);
      tick();
      idle_inputs();
    end
    #1 chk("mem_stall_cnt", 32'(stall_cnt), 3);

    // Reset in the middle of WAIT abandons the access.
    mem_req_m = 1;
    tick();
    tick();
    rst_n = 0;
    #1;
    chk("rst_wait_stall_m", 32'(stall_m), 0);
    chk("rst_wait_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_wait_flush_cnt", 32'(flush_cnt), 0);
    rst_n = 1; mem_req_m = 0;
    tick();
    nstall = 0;
    for (int i = 0; i < 5; i++) begin
      mem_req_m = (i < 4);
      #1 if (stall_m) nstall++;
      tick();
    end
    idle_inputs();
    chk("rst_fresh_stalls", 32'(nstall), 3);
    #1 chk("rst_fresh_stall_cnt", 32'(stall_cnt), 3);

    // Saturation on the 2-bit counters, then clear beating a live stall.
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    load_use();
    for (int i = 0; i < 5; i++) tick();
    chk("sat_stall_cnt", 32'(s_stall_cnt), 3);
    chk("sat_flush_cnt", 32'(s_flush_cnt), 3);
    chk("wide_stall_cnt", 32'(stall_cnt), 5);
    cnt_clr = 1;
    tick();
    chk("clr_over_inc", 32'(s_stall_cnt), 0);
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
